mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory access stage: lane steering and byte enables for stores, load extraction and extension.
// The load result and the misaligned flag are registered once per cycle for writeback.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] d_mem_i,
    input  logic        mem_re_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_f3_i,
    output logic [31:0] d_mem_addr_o,
    output logic        d_mem_re_o,
    output logic        d_mem_we_o,
    output logic [3:0]  d_mem_be_o,
    output logic [31:0] d_mem_wdata_o,
    output logic [31:0] result_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;
    logic        load_mis;
    logic        store_mis;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_data;

    assign d_mem_addr_o = {alu_i[31:2], 2'b00};

    always_comb begin
        byte_val = d_mem_i[7:0];
        case (alu_i[1:0])
            2'b00: byte_val = d_mem_i[7:0];
            2'b01: byte_val = d_mem_i[15:8];
            2'b10: byte_val = d_mem_i[23:16];
            2'b11: byte_val = d_mem_i[31:24];
            default: byte_val = d_mem_i[7:0];
        endcase
        half_val = alu_i[1] ? d_mem_i[31:16] : d_mem_i[15:0];
    end

    // Unused funct3 codes 011/110/111 fall into the word path.
    always_comb begin
        load_data = d_mem_i;
        load_mis  = (alu_i[1:0] != 2'b00);
        case (mem_f3_i)
            3'b000: begin
                load_data = {{24{byte_val[7]}}, byte_val};
                load_mis  = 1'b0;
            end
            3'b100: begin
                load_data = {24'h000000, byte_val};
                load_mis  = 1'b0;
            end
            3'b001: begin
                load_data = {{16{half_val[15]}}, half_val};
                load_mis  = alu_i[0];
            end
            3'b101: begin
                load_data = {16'h0000, half_val};
                load_mis  = alu_i[0];
            end
            default: begin
                load_data = d_mem_i;
                load_mis  = (alu_i[1:0] != 2'b00);
            end
        endcase
        if (load_mis) begin
            load_data = 32'h0000_0000;
        end
    end

    always_comb begin
        store_be   = 4'b1111;
        store_data = wdata_i;
        store_mis  = (alu_i[1:0] != 2'b00);
        case (mem_f3_i[1:0])
            2'b00: begin
                store_be   = 4'b0001 << alu_i[1:0];
                store_data = {4{wdata_i[7:0]}};
                store_mis  = 1'b0;
            end
            2'b01: begin
                store_be   = 4'b0011 << {alu_i[1], 1'b0};
                store_data = {2{wdata_i[15:0]}};
                store_mis  = alu_i[0];
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata_i;
                store_mis  = (alu_i[1:0] != 2'b00);
            end
        endcase
    end

    // A store always takes priority over a simultaneous load request.
    assign misaligned    = mem_wr_i ? store_mis : load_mis;
    assign d_mem_re_o    = mem_re_i & ~mem_wr_i;
    assign d_mem_we_o    = mem_wr_i & ~misaligned;
    assign d_mem_be_o    = d_mem_we_o ? store_be : 4'b0000;
    assign d_mem_wdata_o = mem_wr_i ? store_data : 32'h0000_0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_o     <= 32'h0000_0000;
            misaligned_o <= 1'b0;
        end else begin
            result_o     <= d_mem_re_o ? load_data : alu_i;
            misaligned_o <= (mem_re_i | mem_wr_i) & misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, conflict and async reset,
// each against hand-computed expected values.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_i;
    logic [31:0] wdata_i;
    logic [31:0] d_mem_i;
    logic        mem_re_i;
    logic        mem_wr_i;
    logic [2:0]  mem_f3_i;
    logic [31:0] d_mem_addr_o;
    logic        d_mem_re_o;
    logic        d_mem_we_o;
    logic [3:0]  d_mem_be_o;
    logic [31:0] d_mem_wdata_o;
    logic [31:0] result_o;
    logic        misaligned_o;

    int n_checks;
    int n_fails;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .alu_i         (alu_i),
        .wdata_i       (wdata_i),
        .d_mem_i       (d_mem_i),
        .mem_re_i      (mem_re_i),
        .mem_wr_i      (mem_wr_i),
        .mem_f3_i      (mem_f3_i),
        .d_mem_addr_o  (d_mem_addr_o),
        .d_mem_re_o    (d_mem_re_o),
        .d_mem_we_o    (d_mem_we_o),
        .d_mem_be_o    (d_mem_be_o),
        .d_mem_wdata_o (d_mem_wdata_o),
        .result_o      (result_o),
        .misaligned_o  (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply a request at the falling edge; comb outputs are then valid after #1.
    task automatic drive(input logic re, input logic wr, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd);
        @(negedge clk);
        mem_re_i = re;
        mem_wr_i = wr;
        mem_f3_i = f3;
        alu_i    = alu;
        wdata_i  = wd;
        #1;
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] exp_res, input logic exp_mis);
        drive(1'b1, 1'b0, f3, alu, 32'h0);
        check({tag, "_re"}, {31'b0, d_mem_re_o}, 32'd1);
        check({tag, "_we"}, {31'b0, d_mem_we_o}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_mis"}, {31'b0, misaligned_o}, {31'b0, exp_mis});
    endtask

    task automatic store_check(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [3:0] exp_be,
                               input logic [31:0] exp_wd, input logic exp_we);
        drive(1'b0, 1'b1, f3, alu, wd);
        check({tag, "_addr"}, d_mem_addr_o, {alu[31:2], 2'b00});
        check({tag, "_be"}, {28'b0, d_mem_be_o}, {28'b0, exp_be});
        check({tag, "_wd"}, d_mem_wdata_o, exp_wd);
        check({tag, "_we"}, {31'b0, d_mem_we_o}, {31'b0, exp_we});
        @(posedge clk);
        #1;
        check({tag, "_res"}, result_o, alu);
        check({tag, "_mis"}, {31'b0, misaligned_o}, {31'b0, ~exp_we});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        mem_re_i = 1'b0;
        mem_wr_i = 1'b0;
        mem_f3_i = 3'b000;
        alu_i    = 32'h0;
        wdata_i  = 32'h0;
        d_mem_i  = 32'h80F1_7F23;
        #1;
        check("rst_res", result_o, 32'h0);
        check("rst_mis", {31'b0, misaligned_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        load_check("lb_88",  3'b000, 32'h88, 32'h0000_0023, 1'b0);
        load_check("lb_89",  3'b000, 32'h89, 32'h0000_007F, 1'b0);
        load_check("lb_8a",  3'b000, 32'h8A, 32'hFFFF_FFF1, 1'b0);
        load_check("lb_8b",  3'b000, 32'h8B, 32'hFFFF_FF80, 1'b0);
        load_check("lbu_8a", 3'b100, 32'h8A, 32'h0000_00F1, 1'b0);
        load_check("lbu_8b", 3'b100, 32'h8B, 32'h0000_0080, 1'b0);
        load_check("lh_88",  3'b001, 32'h88, 32'h0000_7F23, 1'b0);
        load_check("lh_8a",  3'b001, 32'h8A, 32'hFFFF_80F1, 1'b0);
        load_check("lhu_8a", 3'b101, 32'h8A, 32'h0000_80F1, 1'b0);
        load_check("lw_88",  3'b010, 32'h88, 32'h80F1_7F23, 1'b0);
        load_check("lh_89",  3'b001, 32'h89, 32'h0000_0000, 1'b1);
        load_check("lhu_8b", 3'b101, 32'h8B, 32'h0000_0000, 1'b1);
        load_check("lw_8a",  3'b010, 32'h8A, 32'h0000_0000, 1'b1);
        load_check("f3_111", 3'b111, 32'h8C, 32'h80F1_7F23, 1'b0);
        load_check("f3_011", 3'b011, 32'h8D, 32'h0000_0000, 1'b1);

        store_check("sb_88", 3'b000, 32'h88, 32'h0000_00AB, 4'b0001, 32'hABAB_ABAB, 1'b1);
        store_check("sb_89", 3'b000, 32'h89, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 1'b1);
        store_check("sb_8a", 3'b000, 32'h8A, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB, 1'b1);
        store_check("sb_8b", 3'b000, 32'h8B, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 1'b1);
        store_check("sh_88", 3'b001, 32'h88, 32'h5555_CDEF, 4'b0011, 32'hCDEF_CDEF, 1'b1);
        store_check("sh_8a", 3'b001, 32'h8A, 32'h5555_CDEF, 4'b1100, 32'hCDEF_CDEF, 1'b1);
        store_check("sw_88", 3'b010, 32'h88, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b1);
        store_check("sh_8b", 3'b001, 32'h8B, 32'h5555_CDEF, 4'b0000, 32'hCDEF_CDEF, 1'b0);
        store_check("sw_8a", 3'b010, 32'h8A, 32'h1122_3344, 4'b0000, 32'h1122_3344, 1'b0);

        // Load and store requested together: the store goes out, no read.
        drive(1'b1, 1'b1, 3'b010, 32'h88, 32'hDEAD_BEEF);
        check("both_re", {31'b0, d_mem_re_o}, 32'd0);
        check("both_we", {31'b0, d_mem_we_o}, 32'd1);
        check("both_be", {28'b0, d_mem_be_o}, 32'h0000_000F);
        check("both_wd", d_mem_wdata_o, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("both_res", result_o, 32'h88);

        // No memory request, word code with an unaligned address: not flagged.
        drive(1'b0, 1'b0, 3'b010, 32'h1235, 32'hFFFF_FFFF);
        check("nomem_be", {28'b0, d_mem_be_o}, 32'd0);
        check("nomem_wd", d_mem_wdata_o, 32'h0);
        check("nomem_re", {31'b0, d_mem_re_o}, 32'd0);
        @(posedge clk);
        #1;
        check("nomem_res", result_o, 32'h1235);
        check("nomem_mis", {31'b0, misaligned_o}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0);
        @(posedge clk);
        #1;
        check("alu_res", result_o, 32'h1234);

        // Misaligned store leaves result=alu and flag set, then reset mid-cycle.
        store_check("sw_8e", 3'b010, 32'h8E, 32'h0, 4'b0000, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_res", result_o, 32'h0);
        check("arst_mis", {31'b0, misaligned_o}, 32'd0);
        alu_i = 32'h0000_1237;
        #1;
        check("arst_addr", d_mem_addr_o, 32'h0000_1234);
        @(posedge clk);
        #1;
        check("arst_hold", result_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        load_check("post_rst", 3'b000, 32'h8B, 32'hFFFF_FF80, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
